// File: rtl/bus_arbiter.sv
// Bus ownership arbiter: the processor owns the bus by default, and DMA requesters take it round-robin.
// Each DMA tenure has a burst limit, and every change of owner passes through a one-cycle turnaround with no grant asserted.
module bus_arbiter #(
    parameter int  NREQ      = 4,
    parameter int  MAX_BURST = 16,
    localparam int ID_W      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_busy,
    input  logic [NREQ-1:0] dreq,
    input  logic [NREQ-1:0] dlast,
    output logic            gnt_cpu,
    output logic [NREQ-1:0] gnt_dma,
    output logic [ID_W-1:0] owner,
    output logic            bus_idle,
    output logic            preempt
);

    typedef enum logic [1:0] {
        ST_CPU_OWN = 2'b00,
        ST_HANDOFF = 2'b01,
        ST_DMA_OWN = 2'b10,
        ST_RETURN  = 2'b11
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic            gnt_cpu_q, gnt_cpu_d;
    logic [NREQ-1:0] gnt_dma_q, gnt_dma_d;
    logic            bus_idle_q, bus_idle_d;
    logic            preempt_q, preempt_d;

    logic [ID_W:0]   pick_s;
    logic            own_req_s;
    logic            own_last_s;
    logic            limit_s;
    logic            exit_s;

    // First requester at or after ptr, wrapping; the MSB of the result flags that a winner was found.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] req, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] n;
        if (id == ID_W'(NREQ - 1)) begin
            n = '0;
        end else begin
            n = id + ID_W'(1'b1);
        end
        return n;
    endfunction

    assign pick_s     = rr_pick(dreq, rr_ptr_q);
    assign own_req_s  = dreq[owner_q];
    assign own_last_s = dlast[owner_q];
    assign limit_s    = (burst_cnt_q == BURST_LAST);
    assign exit_s     = own_last_s || !own_req_s || limit_s;

    // Next-state and next-output decode; the outputs are registered and follow the state being entered.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_cpu_d   = 1'b0;
        gnt_dma_d   = '0;
        bus_idle_d  = 1'b0;
        preempt_d   = 1'b0;

        case (state_q)
            ST_CPU_OWN: begin
                if ((|dreq) && !cpu_busy) begin
                    state_d    = ST_HANDOFF;
                    bus_idle_d = 1'b1;
                end else begin
                    gnt_cpu_d  = 1'b1;
                end
            end
            ST_HANDOFF: begin
                if (pick_s[ID_W]) begin
                    state_d     = ST_DMA_OWN;
                    owner_d     = pick_s[ID_W-1:0];
                    burst_cnt_d = 8'd0;
                    gnt_dma_d   = id_to_onehot(pick_s[ID_W-1:0]);
                end else begin
                    state_d     = ST_CPU_OWN;
                    gnt_cpu_d   = 1'b1;
                end
            end
            ST_DMA_OWN: begin
                // burst_cnt only advances while below the limit, so it can never wrap.
                if (exit_s) begin
                    state_d     = ST_RETURN;
                    bus_idle_d  = 1'b1;
                    rr_ptr_d    = next_id(owner_q);
                    preempt_d   = limit_s && !own_last_s;
                end else begin
                    gnt_dma_d   = id_to_onehot(owner_q);
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            ST_RETURN: begin
                state_d   = ST_CPU_OWN;
                gnt_cpu_d = 1'b1;
            end
            default: begin
                state_d   = ST_CPU_OWN;
                gnt_cpu_d = 1'b1;
            end
        endcase
    end

    // State and output registers; the asynchronous reset drops any DMA grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CPU_OWN;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= 8'd0;
            gnt_cpu_q   <= 1'b1;
            gnt_dma_q   <= '0;
            bus_idle_q  <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_cpu_q   <= gnt_cpu_d;
            gnt_dma_q   <= gnt_dma_d;
            bus_idle_q  <= bus_idle_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt_cpu  = gnt_cpu_q;
    assign gnt_dma  = gnt_dma_q;
    assign owner    = owner_q;
    assign bus_idle = bus_idle_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: runs a vector table and hand-written multi-cycle sequences.
// Expected outputs are queued when stimulus is driven and compared after the clock edge.
module tb_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 16;

    logic       clk;
    logic       rst_n;
    logic       cpu_busy;
    logic [3:0] dreq;
    logic [3:0] dlast;
    logic       gnt_cpu;
    logic [3:0] gnt_dma;
    logic [1:0] owner;
    logic       bus_idle;
    logic       preempt;

    typedef struct packed {
        logic       cpu;
        logic [3:0] dma;
        logic [1:0] own;
        logic       idle;
        logic       pre;
    } out_t;

    typedef struct {
        logic       busy;
        logic [3:0] req;
        logic [3:0] last;
        out_t       exp;
        string      name;
    } vec_t;

    out_t exp_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_busy (cpu_busy),
        .dreq     (dreq),
        .dlast    (dlast),
        .gnt_cpu  (gnt_cpu),
        .gnt_dma  (gnt_dma),
        .owner    (owner),
        .bus_idle (bus_idle),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o(input logic c, input logic [3:0] d, input logic [1:0] ow,
                               input logic i, input logic p);
        out_t r;
        r = {c, d, ow, i, p};
        return r;
    endfunction

    task automatic check(input string nm);
        out_t got;
        out_t e;
        e   = exp_q.pop_front();
        got = {gnt_cpu, gnt_dma, owner, bus_idle, preempt};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got cpu=%b dma=%b own=%0d idle=%b pre=%b, want cpu=%b dma=%b own=%0d idle=%b pre=%b",
                     nm, got.cpu, got.dma, got.own, got.idle, got.pre,
                     e.cpu, e.dma, e.own, e.idle, e.pre);
        end
    endtask

    task automatic step(input logic b, input logic [3:0] r, input logic [3:0] l,
                        input out_t e, input string nm);
        cpu_busy = b;
        dreq     = r;
        dlast    = l;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    task automatic add(input logic b, input logic [3:0] r, input logic [3:0] l,
                       input out_t e, input string nm);
        vec_t v;
        v.busy = b; v.req = r; v.last = l; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    // Grant exclusivity and one-hot invariant, checked every cycle.
    always @(negedge clk) begin
        total++;
        if ((gnt_cpu && (|gnt_dma)) || !$onehot0(gnt_dma) || (bus_idle && (gnt_cpu || (|gnt_dma)))) begin
            bad++;
            $display("FAIL invariant: got cpu=%b dma=%b idle=%b", gnt_cpu, gnt_dma, bus_idle);
        end
    end

    initial begin
        cpu_busy = 1'b0;
        dreq     = 4'b0000;
        dlast    = 4'b0000;
        rst_n    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        check("reset_values");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single request on channel 1, dlast on its third grant cycle.
        add(1'b0, 4'b0010, 4'b0000, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "single_handoff");
        add(1'b0, 4'b0010, 4'b0000, o(1'b0, 4'b0010, 2'd1, 1'b0, 1'b0), "single_grant1");
        add(1'b0, 4'b0010, 4'b0000, o(1'b0, 4'b0010, 2'd1, 1'b0, 1'b0), "single_grant2");
        add(1'b0, 4'b0010, 4'b0000, o(1'b0, 4'b0010, 2'd1, 1'b0, 1'b0), "single_grant3");
        add(1'b0, 4'b0010, 4'b0010, o(1'b0, 4'b0000, 2'd1, 1'b1, 1'b0), "single_return");
        add(1'b0, 4'b0000, 4'b0000, o(1'b1, 4'b0000, 2'd1, 1'b0, 1'b0), "single_cpu_back");
        // Busy stall for five cycles; rr_ptr is now 2, so the scan wraps around to channel 0.
        for (int i = 0; i < 5; i++) begin
            add(1'b1, 4'b0001, 4'b0000, o(1'b1, 4'b0000, 2'd1, 1'b0, 1'b0), "busy_stall");
        end
        add(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0000, 2'd1, 1'b1, 1'b0), "busy_handoff");
        add(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0001, 2'd0, 1'b0, 1'b0), "busy_grant");
        add(1'b0, 4'b0001, 4'b0001, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "busy_return");
        add(1'b0, 4'b0000, 4'b0000, o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0), "busy_cpu_back");
        // One-cycle request pulse aborts the handoff.
        add(1'b0, 4'b0100, 4'b0000, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "abort_handoff");
        add(1'b0, 4'b0000, 4'b0000, o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0), "abort_cpu_back");
        add(1'b0, 4'b0000, 4'b0000, o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0), "abort_hold");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].busy, tbl[i].req, tbl[i].last, tbl[i].exp, tbl[i].name);
        end

        // Burst limit: 16 grant cycles, preempt pulse, one CPU cycle, then a re-grant.
        step(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "burst_handoff");
        step(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0001, 2'd0, 1'b0, 1'b0), "burst_grant");
        for (int i = 0; i < MAX_BURST - 1; i++) begin
            step(1'b0, 4'b0001, 4'b1110, o(1'b0, 4'b0001, 2'd0, 1'b0, 1'b0), "burst_hold");
        end
        step(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b1), "burst_preempt");
        step(1'b0, 4'b0001, 4'b0000, o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0), "burst_cpu_gap");
        step(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "burst_rehandoff");
        step(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0001, 2'd0, 1'b0, 1'b0), "burst_regrant");
        for (int i = 0; i < MAX_BURST - 1; i++) begin
            step(1'b0, 4'b0001, 4'b0000, o(1'b0, 4'b0001, 2'd0, 1'b0, 1'b0), "burst_hold2");
        end
        step(1'b0, 4'b0001, 4'b0001, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "limit_with_dlast");
        step(1'b0, 4'b0000, 4'b0000, o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0), "limit_cpu_back");

        // Reset asserted mid-tenure, away from any clock edge.
        step(1'b0, 4'b0100, 4'b0000, o(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0), "rst_handoff");
        step(1'b0, 4'b0100, 4'b0000, o(1'b0, 4'b0100, 2'd2, 1'b0, 1'b0), "rst_grant");
        step(1'b0, 4'b0100, 4'b0000, o(1'b0, 4'b0100, 2'd2, 1'b0, 1'b0), "rst_grant2");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        check("async_reset");
        dreq = 4'b1111;
        @(posedge clk);
        #1;
        exp_q.push_back(o(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        check("reset_hold");
        #2;
        rst_n = 1'b1;

        // Round robin with all four requesting: the grant order is 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            logic [1:0] id;
            logic [1:0] prev;
            logic [3:0] oh;
            id   = 2'(k % 4);
            prev = (k == 0) ? 2'd0 : 2'((k - 1) % 4);
            oh   = 4'b0001 << id;
            step(1'b0, 4'b1111, 4'b0000, o(1'b0, 4'b0000, prev, 1'b1, 1'b0), "rr_handoff");
            step(1'b0, 4'b1111, 4'b0000, o(1'b0, oh, id, 1'b0, 1'b0), "rr_grant");
            step(1'b0, 4'b1111, oh, o(1'b0, 4'b0000, id, 1'b1, 1'b0), "rr_return");
            step(1'b0, 4'b1111, 4'b0000, o(1'b1, 4'b0000, id, 1'b0, 1'b0), "rr_cpu");
        end

        dreq = 4'b0000;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
